// File: rtl/alu_seq_defs_pkg.sv
// Shared op codes, slice select codes and state encoding for the serial ALU sequencer.
package alu_seq_defs_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NOR  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_ADD  = 3'd5,
    OP_SUB  = 3'd6,
    OP_SLT  = 3'd7
  } op_e;

  localparam logic [2:0] SEL_ADDER = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that route through the slice adder.
  function automatic logic uses_adder(op_e o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_SLT);
  endfunction

  function automatic logic negates_b(op_e o);
    return (o == OP_SUB) || (o == OP_SLT);
  endfunction

  // Logic ops map one-to-one onto slice selects; arithmetic uses the adder.
  function automatic logic [2:0] slice_sel_of(op_e o);
    return uses_adder(o) ? SEL_ADDER : 3'(o);
  endfunction

endpackage

// File: rtl/alu_seq_bitctr.sv
// Bit counter for the serial sequencer: clears on load, steps on enable, flags the MSB cycle.
module alu_seq_bitctr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic last_c
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_c = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last_c ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Drives one external 1-bit ALU slice across a WIDTH-bit operation, LSB first.
// Define ALU_SEQ_SLT_EN to implement op 7 as set-less-than; otherwise op 7 reports err.
module alu_serial_sequencer
  import alu_seq_defs_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_carryin,
  output logic [2:0]       slice_sel,
  output logic             slice_negate,
  input  logic             slice_out,
  input  logic             slice_carryout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ALU_SEQ_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [2:0]       sel_q, sel_d;
  logic             negate_q, negate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  op_e              op_in;
  logic             accept_c;
  logic             last_c;
  logic             ovf_c;
  logic             addsub_c;
  logic [WIDTH-1:0] shifted_c;

  assign op_in = op_e'(op);

  alu_seq_bitctr #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bitctr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept_c),
    .en      (state_q == ST_RUN),
    .last_c  (last_c)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    result_d   = result_q;
    carry_d    = carry_q;
    sel_d      = sel_q;
    negate_d   = negate_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    accept_c   = 1'b0;

    // Overflow is the carry into the MSB (still in carry_q) XOR the carry out of it.
    ovf_c     = carry_q ^ slice_carryout;
    addsub_c  = (op_q == OP_ADD) || (op_q == OP_SUB);
    shifted_c = {slice_out, result_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((op_in == OP_SLT) && !SLT_EN) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            err_d      = 1'b1;
            result_d   = '0;
            carryout_d = 1'b0;
            overflow_d = 1'b0;
            zero_d     = 1'b0;
          end else begin
            accept_c = 1'b1;
            state_d  = ST_RUN;
            busy_d   = 1'b1;
            op_d     = op_in;
            a_sh_d   = a;
            b_sh_d   = b;
            carry_d  = negates_b(op_in);
            sel_d    = slice_sel_of(op_in);
            negate_d = negates_b(op_in);
          end
        end
      end

      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        result_d = shifted_c;
        carry_d  = slice_carryout;
        if (last_c) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          carry_d  = 1'b0;
          sel_d    = 3'd0;
          negate_d = 1'b0;
          if (SLT_EN && (op_q == OP_SLT)) begin
            result_d   = WIDTH'(slice_out ^ ovf_c);
            carryout_d = 1'b0;
            overflow_d = 1'b0;
          end else begin
            carryout_d = addsub_c & slice_carryout;
            overflow_d = addsub_c & ovf_c;
          end
          zero_d = (result_d == '0);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_AND;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      sel_q      <= 3'd0;
      negate_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      sel_q      <= sel_d;
      negate_q   <= negate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign result        = result_q;
  assign carryout      = carryout_q;
  assign overflow      = overflow_q;
  assign zero          = zero_q;
  assign slice_a       = a_sh_q[0];
  assign slice_b       = b_sh_q[0];
  assign slice_carryin = carry_q;
  assign slice_sel     = sel_q;
  assign slice_negate  = negate_q;

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Sequences one external 1-bit ALU slice (AND/NOR/OR/XOR/NAND/ADD-SUB, 3-bit select, negate input, carry in/out) across a WIDTH-bit operation, one bit per clock, LSB first.
- Owns the carry register, the bit counter, the operand and result shift registers, and a start/done handshake.
- Sits between the lab register file/control and a single shared slice instance.
- Trades latency for area.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  3  operation; 0 AND, 1 NOR, 2 OR, 3 XOR, 4 NAND, 5 ADD, 6 SUB, 7 SLT.
a  input  WIDTH  operand A, captured on accept.
b  input  WIDTH  operand B, captured on accept.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when result is valid.
err  output  1  valid with done; unsupported op.
result  output  WIDTH  held from done until next accept.
carryout  output  1  final slice carry (ADD/SUB only, else 0).
overflow  output  1  signed overflow (ADD/SUB only, else 0).
zero  output  1  result == 0.
slice_a  output  1  current A bit to slice.
slice_b  output  1  current B bit to slice.
slice_carryin  output  1  carry to slice.
slice_sel  output  3  slice select: 0 AND, 1 NOR, 2 OR, 3 XOR, 4 NAND, 5 adder.
slice_negate  output  1  inverts B in slice adder.
slice_out  input  1  slice result bit.
slice_carryout  input  1  slice carry.

Behaviour:
Reset (async, reset_n=0):
- State IDLE; all outputs 0; internal registers cleared.
- Reset mid-RUN aborts the operation; no done is produced.

States: IDLE -> RUN -> DONE -> IDLE.

IDLE:
- start=1 with op 0..6: latch a, b, op; bit counter=0; carry register = 1 if SUB, else 0; go to RUN.
- op 7 without SLT support: go to DONE directly with err=1, result=0, flags 0.
- start is ignored in RUN and DONE; no queuing.

RUN (exactly WIDTH cycles):
- slice_a/slice_b = bit[counter] of the latched operands.
- slice_carryin = carry register.
- slice_sel = op for logic ops, 5 for ADD/SUB/SLT.
- slice_negate = 1 for SUB/SLT, else 0. Driven 0 outside RUN.
- Each edge: result bit[counter] <= slice_out; carry <= slice_carryout; counter++.
- On the edge where counter = WIDTH-1: record carry-into-MSB (the incoming carry register) and go to DONE.

DONE (1 cycle):
- done=1; flags and result valid.
- carryout = last slice_carryout.
- overflow = carry-into-MSB XOR carryout.
- zero computed on the final result.

Latency: accept edge plus WIDTH RUN cycles; done is high in cycle WIDTH+1 after the accept edge.

Outputs hold until the next accept. busy=0 in DONE.

Optional Feature:
ALU_SEQ_SLT_EN:
- Defined: op 7 = SLT. Runs as SUB; in DONE, result = {WIDTH-1 zeros, MSB XOR overflow}; carryout=0; overflow=0; err=0.
- Undefined: op 7 returns err=1 with result 0 after one cycle, as described above.

Decomposition:
- Shared constants header alu_seq_defs: op codes, slice select codes, state encoding.
- One natural sub-module, alu_seq_bitctr: counter with clog2(WIDTH) width, load, enable, and a last-bit flag.
- The slice itself is instantiated outside the sequencer.

Test Plan:
All cases use WIDTH=8 and a bench model of the slice.
1. ADD a=0x7F, b=0x01 -> result 0x80, overflow=1, carryout=0, zero=0; done exactly 9 cycles after the accept edge.
2. SUB a=0x05, b=0x05 -> result 0x00, zero=1, carryout=1, overflow=0; slice_carryin=1 on the first RUN cycle.
3. AND 0xF0,0x3C -> 0x30; then NOR 0xF0,0x0F -> 0x00, zero=1; carryout=0 and overflow=0 for both.
4. start pulsed mid-RUN with different operands -> ignored; first result unchanged, exactly one done pulse.
5. reset_n low at RUN cycle 4 -> all outputs 0 immediately; no done; a new ADD 0x03+0x04 afterward -> 0x07.
6. op 7, a=0xFF, b=0x01: with ALU_SEQ_SLT_EN -> result 0x01, err=0 at cycle 9; without it -> err=1, result 0, done one cycle after accept.
